// File: rtl/internal_framebuffer_stream_ctrl.sv
// internal_framebuffer_stream_ctrl
//   Scans a rectangular framebuffer region out as a pixel stream. Addresses are
//   issued to the framebuffer reader (fixed latency, no ready). Each address is
//   issued only when a FIFO slot is reserved for its returning pixel. Pixels are
//   buffered in that FIFO and presented on an AXI-Stream style master port.
//
//   Ports
//     clk, reset           : clock, synchronous active-high reset
//     start, conf*         : scan request and region geometry (latched on start)
//     busy, done           : scan in progress / one-cycle end-of-scan pulse
//     arvalid/arlast/araddr: read requests to the reader (one per asserted cycle)
//     rvalid/rlast/rdata   : reader returns, READ_LATENCY cycles after arvalid
//     m_axis_*             : pixel stream out
//
//   Optional macro FRAMEBUFFER_STREAM_LINE_LAST_EN: when defined, m_axis_tlast
//   marks the last pixel of every line; otherwise only the final region pixel.
module internal_framebuffer_stream_ctrl #(
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int PIXEL_WIDTH                  = 32,
  parameter int DIM_WIDTH                    = 11,
  parameter int READ_LATENCY                 = 2,
  parameter int FIFO_DEPTH                   = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG-1:0] confBase,
  input  logic [DIM_WIDTH-1:0]                    confWidth,
  input  logic [DIM_WIDTH-1:0]                    confHeight,
  input  logic [DIM_WIDTH-1:0]                    confStride,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    arvalid,
  output logic                                    arlast,
  output logic [FRAMEBUFFER_SIZE_IN_PIXEL_LG-1:0] araddr,
  input  logic                                    rvalid,
  input  logic                                    rlast,
  input  logic [PIXEL_WIDTH-1:0]                  rdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic [PIXEL_WIDTH-1:0]                  m_axis_tdata
);

  localparam int AW    = FRAMEBUFFER_SIZE_IN_PIXEL_LG;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
  // entry = {frame_last, line_last, data}
  localparam int ENTRY_W = PIXEL_WIDTH + 2;
`else
  // entry = {frame_last, data}
  localparam int ENTRY_W = PIXEL_WIDTH + 1;
`endif
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 arvalid_q, arvalid_d, arlast_q, arlast_d;
  logic [AW-1:0]        araddr_q, araddr_d;
  logic [DIM_WIDTH-1:0] width_q, width_d, height_q, height_d, stride_q, stride_d;
  logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0]        line_base_q, line_base_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 issue, accept, push, pop, full, credit_ok;
  logic                 last_x, last_y;
  logic [CNT_W:0]       credit_used;
  logic [ENTRY_W-1:0]   head, push_entry;

`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
  // Returns arrive in issue order, so a receive-side column counter recovers
  // the end-of-line position without widening the reader interface.
  logic [DIM_WIDTH-1:0] rx_x_q, rx_x_d;
  logic                 rx_line_last;
  assign rx_line_last = (rx_x_q == width_q - DIM_ONE);
  assign push_entry   = {rlast, rx_line_last, rdata};
`else
  assign push_entry   = {rlast, rdata};
`endif

  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[PIXEL_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[PIXEL_WIDTH];

  assign pop    = m_axis_tvalid && m_axis_tready;
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  // Stray returns (after reset, or while idle) have no reservation; drop them.
  assign accept = rvalid && (state_q != IDLE) && (inflight_q != '0);
  assign push   = accept && (!full || pop);

  // A request may only go out if its pixel already has a FIFO slot.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  assign last_x = (x_q == width_q - DIM_ONE);
  assign last_y = (y_q == height_q - DIM_ONE);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    arvalid_d   = 1'b0;
    arlast_d    = 1'b0;
    araddr_d    = araddr_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    issue       = 1'b0;
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
    rx_x_d      = rx_x_q;
    if (push) rx_x_d = rx_line_last ? '0 : rx_x_q + DIM_ONE;
`endif
    case (state_q)
      IDLE: if (start) begin
        width_d  = confWidth;
        height_d = confHeight;
        stride_d = confStride;
        if (confWidth == '0 || confHeight == '0) begin
          done_d = 1'b1;
        end else begin
          busy_d      = 1'b1;
          x_d         = '0;
          y_d         = '0;
          line_base_d = confBase;
          state_d     = ISSUE;
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
          rx_x_d      = '0;
`endif
        end
      end
      ISSUE: if (credit_ok) begin
        issue     = 1'b1;
        arvalid_d = 1'b1;
        araddr_d  = line_base_q + AW'(x_q);
        arlast_d  = last_x && last_y;
        if (last_x) begin
          x_d         = '0;
          y_d         = y_q + DIM_ONE;
          line_base_d = line_base_q + AW'(stride_q);
          if (last_y) state_d = DRAIN;
        end else begin
          x_d = x_q + DIM_ONE;
        end
      end
      DRAIN: if (pop && head[ENTRY_W-1]) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, accept})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arvalid_q   <= 1'b0;
      arlast_q    <= 1'b0;
      araddr_q    <= '0;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
      rx_x_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      arvalid_q   <= arvalid_d;
      arlast_q    <= arlast_d;
      araddr_q    <= araddr_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
      rx_x_q      <= rx_x_d;
`endif
    end
  end

  // FIFO storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign arvalid = arvalid_q;
  assign arlast  = arlast_q;
  assign araddr  = araddr_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(accept && full && !pop));
  a_inflight_range: assert property (@(posedge clk) disable iff (reset) inflight_q <= CNT_W'(FIFO_DEPTH));
  a_depth_cfg: assert property (@(posedge clk) FIFO_DEPTH >= READ_LATENCY + 2);

endmodule

// File: tb/tb_internal_framebuffer_stream_ctrl.sv
// Directed bench for internal_framebuffer_stream_ctrl with a 2-cycle reader model.
module tb_internal_framebuffer_stream_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] confBase = '0;
  logic [10:0] confWidth = '0, confHeight = '0, confStride = '0;
  logic        busy, done, arvalid, arlast;
  logic [17:0] araddr;
  logic        rvalid, rlast;
  logic [31:0] rdata;
  logic        tvalid, tready = 1'b1, tlast;
  logic [31:0] tdata;

  int checks = 0, failures = 0;
  int cyc = 0;

  internal_framebuffer_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .confBase(confBase), .confWidth(confWidth), .confHeight(confHeight), .confStride(confStride),
    .busy(busy), .done(done), .arvalid(arvalid), .arlast(arlast), .araddr(araddr),
    .rvalid(rvalid), .rlast(rlast), .rdata(rdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tdata(tdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader: fixed 2-cycle latency, not cleared by reset (stray returns happen).
  logic        p1v = 0, p2v = 0, p1l = 0, p2l = 0;
  logic [17:0] p1a = '0, p2a = '0;
  always @(posedge clk) begin
    p1v <= arvalid; p1a <= araddr; p1l <= arlast;
    p2v <= p1v;     p2a <= p1a;    p2l <= p1l;
  end
  assign rvalid = p2v;
  assign rlast  = p2l;
  assign rdata  = {14'h2A5, p2a};

  function automatic logic [31:0] pix(input logic [17:0] a);
    return {14'h2A5, a};
  endfunction

  // Monitor, sampled on the falling edge.
  logic [17:0] ar_a[$];
  logic        ar_l[$];
  logic [31:0] bt_d[$];
  logic        bt_l[$];
  int          bt_c[$];
  int first_ar = -1, first_tv = -1, done_cnt = 0, done_cyc = -1, start_cyc = 0;
  logic busy_seen = 1'b0;

  always @(negedge clk) begin
    if (arvalid) begin ar_a.push_back(araddr); ar_l.push_back(arlast); if (first_ar < 0) first_ar = cyc; end
    if (tvalid && first_tv < 0) first_tv = cyc;
    if (tvalid && tready) begin bt_d.push_back(tdata); bt_l.push_back(tlast); bt_c.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ar_a.delete(); ar_l.delete(); bt_d.delete(); bt_l.delete(); bt_c.delete();
    first_ar = -1; first_tv = -1; done_cnt = 0; done_cyc = -1; busy_seen = 1'b0;
  endtask

  task automatic do_start(input logic [17:0] b, input logic [10:0] w, input logic [10:0] h,
                          input logic [10:0] s);
    clear_mon();
    confBase = b; confWidth = w; confHeight = h; confStride = s;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin tick(1); n++; end
    tick(2);
    chk("done_within_budget", 64'(done_cnt != 0), 64'd1);
  endtask

  // Compare recorded requests and beats against the region geometry.
  task automatic check_scan(input int b, input int w, input int h, input int s);
    int n;
    logic [17:0] ea;
    logic el;
    n = w * h;
    chk("ar_count", 64'(ar_a.size()), 64'(n));
    chk("beat_count", 64'(bt_d.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      ea = 18'(b + (i / w) * s + (i % w));
`ifdef FRAMEBUFFER_STREAM_LINE_LAST_EN
      el = ((i % w) == w - 1);
`else
      el = (i == n - 1);
`endif
      if (i < ar_a.size()) begin
        chk($sformatf("araddr[%0d]", i), 64'(ar_a[i]), 64'(ea));
        chk($sformatf("arlast[%0d]", i), 64'(ar_l[i]), 64'(i == n - 1));
      end
      if (i < bt_d.size()) begin
        chk($sformatf("tdata[%0d]", i), 64'(bt_d[i]), 64'(pix(ea)));
        chk($sformatf("tlast[%0d]", i), 64'(bt_l[i]), 64'(el));
      end
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    if (bt_c.size() == n && n > 0)
      chk("done_after_last_beat", 64'(done_cyc), 64'(bt_c[n-1] + 1));
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_arlast", 64'(arlast), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);

    // 1: basic 4x2 region, full rate
    tready = 1'b1;
    do_start(18'h100, 11'd4, 11'd2, 11'd8);
    wait_done(60);
    check_scan(32'h100, 4, 2, 8);
    chk("first_arvalid_latency", 64'(first_ar - start_cyc), 64'd1);
    chk("first_tvalid_latency", 64'(first_tv - start_cyc), 64'd4);
    if (bt_c.size() == 8) chk("full_rate", 64'(bt_c[7] - bt_c[0]), 64'd7);

    // 2: same region stalled 20 cycles; a start/config change mid-scan is ignored
    tready = 1'b0;
    do_start(18'h100, 11'd4, 11'd2, 11'd8);
    confWidth = 11'd1; confBase = 18'h3000; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    chk("stall_ar_count", 64'(ar_a.size()), 64'd8);
    chk("stall_tvalid", 64'(tvalid), 64'd1);
    chk("stall_tdata_hold", 64'(tdata), 64'(pix(18'h100)));
    chk("stall_busy", 64'(busy), 64'd1);
    tready = 1'b1;
    wait_done(60);
    check_scan(32'h100, 4, 2, 8);

    // 3: 6x2 region stalled: credit limits requests to FIFO depth
    tready = 1'b0;
    do_start(18'h200, 11'd6, 11'd2, 11'd8);
    tick(20);
    chk("credit_ar_count", 64'(ar_a.size()), 64'd8);
    tready = 1'b1;
    wait_done(80);
    check_scan(32'h200, 6, 2, 8);

    // 4: zero width
    do_start(18'h300, 11'd0, 11'd5, 11'd8);
    tick(4);
    chk("zero_done_count", 64'(done_cnt), 64'd1);
    chk("zero_done_cycle", 64'(done_cyc), 64'(start_cyc));
    chk("zero_ar_count", 64'(ar_a.size()), 64'd0);
    chk("zero_tvalid_seen", 64'(first_tv), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zero_busy_seen", 64'(busy_seen), 64'd0);

    // 5: address wrap at 2^18
    do_start(18'h3FFFE, 11'd4, 11'd1, 11'd0);
    wait_done(60);
    if (ar_a.size() == 4) begin
      chk("wrap_a0", 64'(ar_a[0]), 64'h3FFFE);
      chk("wrap_a1", 64'(ar_a[1]), 64'h3FFFF);
      chk("wrap_a2", 64'(ar_a[2]), 64'h00000);
      chk("wrap_a3", 64'(ar_a[3]), 64'h00001);
    end
    check_scan(32'h3FFFE, 4, 1, 0);

    // 6: reset with two requests in flight
    do_start(18'h040, 11'd16, 11'd1, 11'd0);
    tick(2);
    chk("pre_reset_arvalid", 64'(arvalid), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_arvalid", 64'(arvalid), 64'd0);
    chk("midrst_araddr", 64'(araddr), 64'd0);
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    reset = 1'b0;
    clear_mon();
    tick(6);
    chk("stray_dropped_tvalid", 64'(first_tv), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stray_no_done", 64'(done_cnt), 64'd0);
    do_start(18'h080, 11'd2, 11'd1, 11'd0);
    wait_done(40);
    check_scan(32'h080, 2, 1, 0);

    // 7: 3x2 region: tlast per line with the macro, frame end only without
    do_start(18'h500, 11'd3, 11'd2, 11'd16);
    wait_done(60);
    check_scan(32'h500, 3, 2, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
